// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine cycle sequencer:
// state codes, lamp bit positions and small state-classification helpers.
package wm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_WASH  = 4'd2,
    ST_DRAIN = 4'd3,
    ST_RINSE = 4'd4,
    ST_SPIN  = 4'd5,
    ST_DONE  = 4'd6
  } state_e;

  localparam int unsigned LAMP_W     = 8;
  localparam int unsigned LAMP_PAUSE = 7;

  // Lamp bit index equals the state code; the top bit mirrors the pause flag.
  function automatic logic [LAMP_W-1:0] lamp_of(input state_e st, input logic paused);
    logic [LAMP_W-1:0] l;
    l             = LAMP_W'(1) << st;
    l[LAMP_PAUSE] = paused;
    return l;
  endfunction

  function automatic logic is_run(input state_e st);
    return st inside {ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: emits a one-cycle tick after every TICK_DIV enabled
// cycles; holds its count while disabled and restarts from zero on clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Washing-machine program sequencer: FILL/WASH/DRAIN/RINSE/SPIN phases timed
// by a one-second tick, with pause, cancel-with-drain and elapsed billing time.
module cycle_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned N_PROG   = 4,
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned LVL_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_p,
  input  logic                      pause_p,
  input  logic                      cancel_p,
  input  logic [$clog2(N_PROG)-1:0] prog_sel,
  input  logic [CNT_W-1:0]          wash_t,
  input  logic [CNT_W-1:0]          rinse_t,
  input  logic [CNT_W-1:0]          spin_t,
  input  logic [2:0]                rinse_n,
  output logic [3:0]                phase,
  output logic [7:0]                st_light,
  output logic [CNT_W-1:0]          remain,
  output logic [2:0]                rinse_left,
  output logic [LVL_W-1:0]          wt_light,
  output logic                      busy,
  output logic                      paused,
  output logic                      done,
  output logic [CNT_W+3:0]          elapsed,
  output logic [$clog2(N_PROG)-1:0] prog_q
);

  localparam int unsigned PW = $clog2(N_PROG);
  localparam int unsigned EW = CNT_W + 4;

  state_e            state_q, state_d;
  logic              paused_q, paused_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        st_light_q, st_light_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [2:0]        rinse_left_q, rinse_left_d;
  logic [LVL_W-1:0]  wt_q, wt_d;
  logic [EW-1:0]     elapsed_q, elapsed_d;
  logic [PW-1:0]     prog_q_q, prog_q_d;
  logic [CNT_W-1:0]  wash_t_q, wash_t_d;
  logic [CNT_W-1:0]  rinse_t_q, rinse_t_d;
  logic [CNT_W-1:0]  spin_t_q, spin_t_d;
  logic              washed_q, washed_d;
  logic              abort_q, abort_d;

  logic tick, tick_en, tick_clr, adv;

  // Prescaler is held on cycles carrying pause/cancel so those events
  // pre-empt a coincident tick without losing the second.
  assign tick_en = is_run(state_q) && !paused_q && !pause_p && !cancel_p;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    paused_d     = paused_q;
    remain_d     = remain_q;
    rinse_left_d = rinse_left_q;
    wt_d         = wt_q;
    elapsed_d    = elapsed_q;
    prog_q_d     = prog_q_q;
    wash_t_d     = wash_t_q;
    rinse_t_d    = rinse_t_q;
    spin_t_d     = spin_t_q;
    washed_d     = washed_q;
    abort_d      = abort_q;
    tick_clr     = 1'b0;
    adv          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          prog_q_d     = prog_sel;
          wash_t_d     = wash_t;
          rinse_t_d    = rinse_t;
          spin_t_d     = spin_t;
          rinse_left_d = rinse_n;
          elapsed_d    = '0;
          remain_d     = '0;
          wt_d         = '0;
          washed_d     = 1'b0;
          abort_d      = 1'b0;
          paused_d     = 1'b0;
          tick_clr     = 1'b1;
          state_d      = ST_FILL;
        end
      end
      ST_DONE: begin
        if (start_p) state_d = ST_IDLE;
      end
      default: begin
        if (cancel_p) begin
          paused_d = 1'b0;
          remain_d = '0;
          if (wt_q != '0) begin
            state_d      = ST_DRAIN;
            rinse_left_d = '0;
            abort_d      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (pause_p) begin
          paused_d = ~paused_q;
        end else if (!paused_q) begin
          if (tick && !(&elapsed_q)) elapsed_d = elapsed_q + 1'b1;
          case (state_q)
            ST_FILL: begin
              if (tick) begin
                wt_d = {wt_q[LVL_W-2:0], 1'b1};
                adv  = &wt_d;
              end
            end
            ST_DRAIN: begin
              if (wt_q == '0) begin
                adv = 1'b1;
              end else if (tick) begin
                wt_d = wt_q >> 1;
                adv  = (wt_d == '0);
              end
            end
            default: begin
              if (remain_q == '0) begin
                adv = 1'b1;
              end else if (tick) begin
                remain_d = remain_q - 1'b1;
                adv      = (remain_q == CNT_W'(1));
              end
            end
          endcase
        end
      end
    endcase

    if (adv) begin
      case (state_q)
        ST_FILL: begin
          if (washed_q) begin
            state_d  = ST_RINSE;
            remain_d = rinse_t_q;
            if (rinse_left_q != '0) rinse_left_d = rinse_left_q - 1'b1;
          end else begin
            state_d  = ST_WASH;
            remain_d = wash_t_q;
          end
        end
        ST_WASH: begin
          state_d  = ST_DRAIN;
          washed_d = 1'b1;
        end
        ST_RINSE: state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (abort_q) begin
            state_d = ST_IDLE;
          end else if (rinse_left_q != '0) begin
            state_d = ST_FILL;
          end else begin
            state_d  = ST_SPIN;
            remain_d = spin_t_q;
          end
        end
        ST_SPIN: state_d = ST_DONE;
        default: ;
      endcase
    end

    busy_d     = is_run(state_d);
    st_light_d = lamp_of(state_d, paused_d);
    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      paused_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      st_light_q   <= lamp_of(ST_IDLE, 1'b0);
      remain_q     <= '0;
      rinse_left_q <= '0;
      wt_q         <= '0;
      elapsed_q    <= '0;
      prog_q_q     <= '0;
      wash_t_q     <= '0;
      rinse_t_q    <= '0;
      spin_t_q     <= '0;
      washed_q     <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      paused_q     <= paused_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      st_light_q   <= st_light_d;
      remain_q     <= remain_d;
      rinse_left_q <= rinse_left_d;
      wt_q         <= wt_d;
      elapsed_q    <= elapsed_d;
      prog_q_q     <= prog_q_d;
      wash_t_q     <= wash_t_d;
      rinse_t_q    <= rinse_t_d;
      spin_t_q     <= spin_t_d;
      washed_q     <= washed_d;
      abort_q      <= abort_d;
    end
  end

  assign phase      = state_q;
  assign st_light   = st_light_q;
  assign remain     = remain_q;
  assign rinse_left = rinse_left_q;
  assign wt_light   = wt_q;
  assign busy       = busy_q;
  assign paused     = paused_q;
  assign done       = done_q;
  assign elapsed    = elapsed_q;
  assign prog_q     = prog_q_q;

endmodule
